// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; quotient -> lo_o, remainder -> hi_o.
// Optional: define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle instead of WIDTH.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       alucontrol,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
    localparam int         CW          = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             by_zero;

    logic             is_div;
    logic             signed_op;
    logic             start;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        is_div    = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
        signed_op = (alucontrol == EXE_DIV_OP);
        start     = (state == IDLE) && valid_i && is_div && !annul;
        stall_o   = resetn && !annul && (start || (state == BUSY));
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

        // quo starts out holding the dividend; its MSBs feed rem while quotient bits fill from the LSB.
        rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
        rem_nx = trial[WIDTH] ? rem_sh : trial;
        quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
        q_fix  = neg_q ? -quo_nx : quo_nx;
        r_fix  = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
            ready_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            ready_o <= 1'b0;
            if (annul) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cnt     <= '0;
                            rem     <= '0;
                            quo     <= a_mag;
                            dvs     <= b_mag;
                            dvd_raw <= a;
                            neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r   <= signed_op && a[WIDTH-1];
                            by_zero <= (b == '0);
                            state   <= BUSY;
`ifdef DIV_ZERO_FAST_EN
                            if (b == '0) begin
                                state   <= DONE;
                                ready_o <= 1'b1;
                                hi_o    <= a;
                                lo_o    <= '1;
                            end
`endif
                        end
                    end
                    BUSY: begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state   <= DONE;
                            ready_o <= 1'b1;
                            if (by_zero) begin
                                hi_o <= dvd_raw;
                                lo_o <= '1;
                            end else begin
                                hi_o <= r_fix;
                                lo_o <= q_fix;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random vectors vs. arithmetic model, annul and reset sequences.
module tb_div_unit;

    localparam logic [7:0] DIV  = 8'b00011010;
    localparam logic [7:0] DIVU = 8'b00011011;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  alucontrol;
    logic        valid_i;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alucontrol (alucontrol),
        .valid_i    (valid_i),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_o    (stall_o),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend).
    task automatic model(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (bv == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = av;
        end else if (op == DIV) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = av / bv;
            hi = av % bv;
        end
    endtask

    function automatic int exp_lat(input logic [31:0] bv);
`ifdef DIV_ZERO_FAST_EN
        if (bv == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Starts a divide at the next falling edge (cycle T) and follows it until ready_o.
    task automatic do_div(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] lo, output logic [31:0] hi, output int lat);
        logic stall_ok;
        @(negedge clk);
        annul      = 1'b0;
        alucontrol = op;
        a          = av;
        b          = bv;
        valid_i    = 1'b1;
        #1 chk("start_stall", 32'(stall_o), 32'd1);
        stall_ok = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            valid_i = 1'b0;
            lat++;
            #1;
            if (!ready_o && stall_o !== 1'b1) stall_ok = 1'b0;
        end while (!ready_o && lat <= 40);
        chk("busy_stall", 32'(stall_ok), 32'd1);
        chk("done_stall", 32'(stall_o), 32'd0);
        lo = lo_o;
        hi = hi_o;
    endtask

    vec_t        vt[11];
    logic [31:0] rlo, rhi, mlo, mhi, ra, rb;
    logic [7:0]  rop;
    int          lat;
    logic        flag;

    initial begin
        vt[0]  = '{DIVU, 32'd100,        32'd7,        32'd14,       32'd2};
        vt[1]  = '{DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vt[2]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        vt[3]  = '{DIVU, 32'h1234,       32'h0,        32'hFFFF_FFFF, 32'h1234};
        vt[4]  = '{DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vt[5]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'h0};
        vt[6]  = '{DIV,  32'd0,          32'd5,        32'd0,        32'd0};
        vt[7]  = '{DIV,  32'hFFFF_FF9C,  32'h0,        32'hFFFF_FFFF, 32'hFFFF_FF9C};
        vt[8]  = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vt[9]  = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE};
        vt[10] = '{DIV,  32'h8000_0000,  32'd1,        32'h8000_0000, 32'h0};

        resetn = 1'b0; valid_i = 1'b0; annul = 1'b0; alucontrol = 8'h00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Non-divide codes and idle div code must not stall or produce a result.
        @(negedge clk);
        alucontrol = 8'h20; valid_i = 1'b1;
        #1 chk("nondiv_stall", 32'(stall_o), 32'd0);
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (ready_o || stall_o) flag = 1'b1;
        end
        alucontrol = DIVU; valid_i = 1'b0;
        #1 chk("novalid_stall", 32'(stall_o), 32'd0);
        valid_i = 1'b1; annul = 1'b1;
        #1 chk("annul_start_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        valid_i = 1'b0; annul = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            if (ready_o || stall_o) flag = 1'b1;
        end
        chk("nondiv_quiet", 32'(flag), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_div(vt[i].op, vt[i].a, vt[i].b, rlo, rhi, lat);
            chk($sformatf("vec%0d_lat", i), lat, exp_lat(vt[i].b));
            chk($sformatf("vec%0d_lo", i), rlo, vt[i].lo);
            chk($sformatf("vec%0d_hi", i), rhi, vt[i].hi);
        end

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3, 4: rb = $urandom_range(1, 16);
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, mlo, mhi);
            do_div(rop, ra, rb, rlo, rhi, lat);
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat(rb));
            chk($sformatf("rnd%0d_lo", i), rlo, mlo);
            chk($sformatf("rnd%0d_hi", i), rhi, mhi);
        end

        // Annul in the middle of a divide, then an immediate restart.
        do_div(DIVU, 32'd100, 32'd7, rlo, rhi, lat);
        chk("pre_annul_lo", rlo, 32'd14);
        @(negedge clk);
        alucontrol = DIVU; a = 32'd50; b = 32'd3; valid_i = 1'b1;
        #1 chk("annul_seq_start", 32'(stall_o), 32'd1);
        flag = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            if (ready_o || !stall_o) flag = 1'b1;
        end
        chk("annul_seq_busy", 32'(flag), 32'd0);
        @(negedge clk);
        annul = 1'b1;
        #1 chk("annul_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("annul_ready", 32'(ready_o), 32'd0);
        chk("annul_hi_hold", hi_o, 32'd2);
        chk("annul_lo_hold", lo_o, 32'd14);
        do_div(DIVU, 32'd9, 32'd4, rlo, rhi, lat);
        chk("post_annul_lat", lat, 33);
        chk("post_annul_lo", rlo, 32'd2);
        chk("post_annul_hi", rhi, 32'd1);

        // Reset in the middle of a divide.
        @(negedge clk);
        alucontrol = DIV; a = 32'hFFFF_FFF9; b = 32'd2; valid_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        resetn = 1'b1;
        flag = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            if (ready_o || stall_o) flag = 1'b1;
        end
        chk("midrst_no_ready", 32'(flag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
